dac_load_sequencer: RTL and testbench
=====================================

# dac_load_sequencer

Sequences waveform loading from the single PS AXI-Stream into the per-channel waveform FIFOs of up to 16 DAC drivers. It walks an enabled-channel mask in ascending index order and steers exactly `load_len` 256-bit beats to each enabled channel. It then raises a per-channel load-complete flag, which channel control uses to start loopback playback. It sits between the PS DMA stream and the `s_axis` inputs of the `dac_driver` instances.

## Interface
- `NUM_CH`, default 16: number of DAC channels served (1..16).
- `LEN_W`, default 16: width of the per-channel beat count.
- `clk` in 1: single clock, shared with the DAC drivers.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse; begins a load pass. Ignored unless idle.
- `abort` in 1: one-cycle pulse; terminates the pass.
- `ch_mask` in NUM_CH: channels to load. Sampled on accepted `start`.
- `load_len` in LEN_W: beats per channel. Sampled on accepted `start`.
- `s_axis_tdata` in 256: PS waveform data.
- `s_axis_tvalid` in 1: PS data valid.
- `s_axis_tlast` in 1: marks the last beat of each channel block.
- `s_axis_tready` out 1: ready back to the PS.
- `m_axis_tdata` out 256: broadcast to all channels.
- `m_axis_tvalid` out NUM_CH: per-channel valid; at most one bit set.
- `m_axis_tready` in NUM_CH: per-channel ready.
- `loaded` out NUM_CH: sticky per-channel load-complete flags.
- `busy` out 1: a pass is in progress.
- `done` out 1: one-cycle pulse at the end of a pass.
- `err` out 1: sticky tlast-mismatch flag.

## Operation
- States are IDLE, SEEK, STREAM and DONE.
- **IDLE**
  - On `start`, latch `ch_mask` into `pend` and `load_len` into `len_q`.
  - Clear `loaded` and `err`, then go to SEEK.
- **SEEK** (exactly 1 cycle)
  - A priority encoder selects the lowest set bit of `pend` as `cur`.
  - If `pend` is 0, go to DONE.
  - If `len_q` is 0, set `loaded[cur]`, clear `pend[cur]` and stay in SEEK; no beats are transferred.
  - Otherwise clear `beat_cnt` and go to STREAM.
- **STREAM**
  - `m_axis_tdata` equals `s_axis_tdata`.
  - `m_axis_tvalid[cur]` equals `s_axis_tvalid`; all other valid bits are 0.
  - `s_axis_tready` equals `m_axis_tready[cur]`.
  - On each handshake, `beat_cnt` increments.
  - On the beat where `beat_cnt == len_q-1`: set `loaded[cur]`, clear `pend[cur]` and go to SEEK.
- **DONE**: pulse `done` for 1 cycle, then return to IDLE.
- **Outside STREAM**: `s_axis_tready` is 0 and all of `m_axis_tvalid` is 0.
- **abort**: in any non-IDLE state, go to IDLE the next cycle.
  - No `done` pulse.
  - `loaded` bits already set are kept.
  - A beat that completes a handshake in the same cycle as `abort` is counted, but causes no state advance.
- **start while busy**: ignored.
- **start and abort together in IDLE**: `abort` wins; the block stays in IDLE.
- **Arithmetic**: `beat_cnt` is LEN_W bits and never wraps, because the pass ends at `len_q-1`. The maximum block length is 2^LEN_W-1 beats.

## Timing
- **Reset values**:
  - State is IDLE.
  - `s_axis_tready`, `m_axis_tvalid`, `busy` and `done` are 0.
  - `loaded` and `err` are 0.
  - `m_axis_tdata` is don't-care and passes `s_axis_tdata` through.
- Reset mid-pass behaves like `abort`, except that `loaded` is also cleared.
- **Datapath latency**: zero. tdata, tvalid and tready are combinational pass-through in STREAM; there is no internal buffering.
- **Handshake**: the AXI-Stream rule holds. The block never makes `m_axis_tvalid` depend on `m_axis_tready`.
- `busy` is a registered output: high from the cycle after an accepted `start` through the DONE cycle.
- **Cycle cost**:
  - Each enabled channel costs 1 SEEK cycle plus `len_q` handshakes.
  - Each pass adds 1 SEEK cycle (empty `pend`) and 1 DONE cycle.
  - With `ch_mask = 0`, `done` is high 2 cycles after `start`.
- `loaded[k]` rises the cycle after the final handshake for channel k.

## Configuration
- `DAC_LOAD_TLAST_CHECK_EN` **defined**: the tlast check is active. Two cases are mismatches:
  - `s_axis_tlast` = 1 on a handshake before the final beat.
  - `s_axis_tlast` = 0 on the final beat.
- On a mismatch: set `err`, finish the current channel's count unchanged, then go to DONE. Remaining channels are skipped and `done` still pulses.
- `DAC_LOAD_TLAST_CHECK_EN` **undefined**:
  - `s_axis_tlast` is ignored.
  - `err` is tied to 0.

## Structure
- Add to the shared `rfsoc_config` package:
  - a state enum `load_state_t` with values IDLE, SEEK, STREAM and DONE;
  - the constant `DAC_AXIS_W` = 256, used for all tdata widths;
  - the constant `MAX_DAC_CH` = 16.
- One sub-module: `lowest_set_idx`, a parameterised priority encoder from `pend` to `cur` plus a valid flag.

## Test plan
- **Two channels, 4 beats**: `ch_mask = 16'h0005`, `load_len = 4`, PS streams 8 beats, all readies high.
  - Beats 0-3 go to channel 0 only; beats 4-7 go to channel 2 only.
  - `loaded = 16'h0005`.
  - `done` pulses 12 cycles after `start`.
- **Backpressure**: `m_axis_tready[0]` toggles every cycle.
  - `s_axis_tready` mirrors it.
  - No beat is lost or duplicated.
  - The data order checks against a scoreboard.
- **Degenerate start**: `ch_mask = 0` gives `done` 2 cycles after `start` and no valids. `load_len = 0` with `ch_mask = 16'h0003` gives `loaded = 16'h0003` and zero transfers.
- **Abort mid-stream**: `abort` after 2 of 4 beats on channel 1.
  - IDLE the next cycle, with no `done` pulse.
  - `loaded[1] = 0`; earlier channels keep their flags.
  - `s_axis_tready` is 0.
- **Early tlast** (`DAC_LOAD_TLAST_CHECK_EN` defined): tlast on beat 2 of 4.
  - `err` = 1 and `done` pulses after beat 3.
  - With the macro undefined, `err` stays 0 and the pass completes normally.
- **start while busy and reset mid-pass**: the second `start` has no effect. `rst` mid-pass clears `loaded` and returns the block to IDLE with all outputs 0.

Source files
------------

// File: rtl/rfsoc_config.sv
// Shared RFSoC configuration: DAC stream widths, channel limits and the loader state encoding.
package rfsoc_config;

    localparam int unsigned DAC_AXIS_W = 256;
    localparam int unsigned MAX_DAC_CH = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEEK,
        STREAM,
        DONE
    } load_state_t;

    // Index width for an n-entry vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lowest_set_idx.sv
// Priority encoder: index of the lowest set bit of vec, plus a flag that any bit is set.
module lowest_set_idx #(
    parameter int unsigned W     = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic [W-1:0]     vec,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    // Scan from the top so the lowest set bit is the last to assign.
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IDX_W'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dac_load_sequencer.sv
// Steers load_len beats from the PS stream to each enabled DAC channel in ascending order.
// Optional tlast/length cross-check enabled by defining DAC_LOAD_TLAST_CHECK_EN.
module dac_load_sequencer
    import rfsoc_config::*;
#(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned LEN_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic [LEN_W-1:0]      load_len,
    input  logic [DAC_AXIS_W-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic [DAC_AXIS_W-1:0] m_axis_tdata,
    output logic [NUM_CH-1:0]     m_axis_tvalid,
    input  logic [NUM_CH-1:0]     m_axis_tready,
    output logic [NUM_CH-1:0]     loaded,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned CUR_W = idx_width(NUM_CH);

    load_state_t       state_q, state_d;
    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] loaded_q, loaded_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              err_q, err_d;
    logic              busy_q;

    logic [CUR_W-1:0]  cur;
    logic              cur_valid;
    logic              stream_hs;
    logic              final_beat;
    logic              mismatch;

    lowest_set_idx #(
        .W     (NUM_CH),
        .IDX_W (CUR_W)
    ) u_lowest_set_idx (
        .vec   (pend_q),
        .idx   (cur),
        .valid (cur_valid)
    );

    assign stream_hs  = (state_q == STREAM) && s_axis_tvalid && m_axis_tready[cur];
    assign final_beat = (beat_cnt_q == len_q - LEN_W'(1));

`ifdef DAC_LOAD_TLAST_CHECK_EN
    assign mismatch = stream_hs && (s_axis_tlast != final_beat);
`else
    logic unused_tlast;
    assign unused_tlast = s_axis_tlast;
    assign mismatch     = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        pend_d        = pend_q;
        loaded_d      = loaded_q;
        len_d         = len_q;
        beat_cnt_d    = beat_cnt_q;
        err_d         = err_q;
        s_axis_tready = 1'b0;
        m_axis_tvalid = '0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    pend_d   = ch_mask;
                    len_d    = load_len;
                    loaded_d = '0;
                    err_d    = 1'b0;
                    state_d  = SEEK;
                end
            end
            SEEK: begin
                if (!cur_valid) begin
                    state_d = DONE;
                end else if (len_q == '0) begin
                    loaded_d[cur] = 1'b1;
                    pend_d[cur]   = 1'b0;
                end else begin
                    beat_cnt_d = '0;
                    state_d    = STREAM;
                end
            end
            STREAM: begin
                m_axis_tvalid[cur] = s_axis_tvalid;
                s_axis_tready      = m_axis_tready[cur];
                if (stream_hs) begin
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    if (mismatch) begin
                        err_d = 1'b1;
                    end
                    if (final_beat) begin
                        loaded_d[cur] = 1'b1;
                        pend_d[cur]   = 1'b0;
                        // A tlast error anywhere in this block ends the pass early.
                        state_d       = (err_q || mismatch) ? DONE : SEEK;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort keeps the beat count but discards any completion from this cycle.
        if (abort && (state_q != IDLE)) begin
            state_d  = IDLE;
            pend_d   = pend_q;
            loaded_d = loaded_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            loaded_q   <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            loaded_q   <= loaded_d;
            len_q      <= len_d;
            beat_cnt_q <= beat_cnt_d;
            err_q      <= err_d;
            busy_q     <= (state_d != IDLE);
        end
    end

    assign m_axis_tdata = s_axis_tdata;
    assign loaded       = loaded_q;
    assign busy         = busy_q;
    assign done         = (state_q == DONE);
    assign err          = err_q;

endmodule

// File: tb/tb_dac_load_sequencer.sv
// Randomised bench for dac_load_sequencer, scored against a beat-list model of each load pass.
module tb_dac_load_sequencer;

    localparam int unsigned NUM_CH = 16;
    localparam int unsigned LEN_W  = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                abort;
    logic [NUM_CH-1:0]   ch_mask;
    logic [LEN_W-1:0]    load_len;
    logic [255:0]        s_axis_tdata;
    logic                s_axis_tvalid;
    logic                s_axis_tlast;
    logic                s_axis_tready;
    logic [255:0]        m_axis_tdata;
    logic [NUM_CH-1:0]   m_axis_tvalid;
    logic [NUM_CH-1:0]   m_axis_tready;
    logic [NUM_CH-1:0]   loaded;
    logic                busy;
    logic                done;
    logic                err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dac_load_sequencer #(
        .NUM_CH (NUM_CH),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .ch_mask       (ch_mask),
        .load_len      (load_len),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .loaded        (loaded),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] rand_data();
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // One load pass. The model is the ordered list of channels every accepted beat must reach.
    task automatic run_pass(input string name, input logic [15:0] mask, input logic [15:0] len,
                            input int rmode, input bit vrand, input int bad_beat,
                            input int abort_at, input int restart_at, input int exp_lat);
        int           exp_ch[$];
        int           blocks[$];
        int           hs_cnt;
        int           cyc;
        int           hs_before;
        bit           saw_done;
        bit           aborted;
        bit           restarted;
        bit           err_case;
        bit           hs;
        logic [15:0]  exp_loaded;
        logic [255:0] cur_data;

        hs_cnt = 0; cyc = 0; hs_before = 0;
        saw_done = 0; aborted = 0; restarted = 0; err_case = 0;
        exp_loaded = '0;
`ifdef DAC_LOAD_TLAST_CHECK_EN
        err_case = (bad_beat >= 0) && (mask != 0) && (len != 0);
`endif
        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (mask[c]) begin
                blocks.push_back(c);
                if (!(err_case && blocks.size() > 1))
                    for (int b = 0; b < int'(len); b++) exp_ch.push_back(c);
            end
        end

        cur_data = rand_data();
        start    = 1'b1;
        ch_mask  = mask;
        load_len = len;
        while (cyc < 4000) begin
            if (cyc > 0) start = 1'b0;
            if (restart_at >= 0 && !restarted && cyc > 0 && hs_cnt == restart_at) begin
                start     = 1'b1;
                ch_mask   = 16'hFFFF;
                load_len  = 16'd1;
                restarted = 1'b1;
            end
            case (rmode)
                0:       m_axis_tready = '1;
                1:       m_axis_tready = {15'h7FFF, cyc[0]};
                default: m_axis_tready = 16'($urandom);
            endcase
            s_axis_tvalid = (hs_cnt < exp_ch.size()) && (!vrand || $urandom_range(0, 3) != 0);
            s_axis_tdata  = cur_data;
            s_axis_tlast  = (len != 0) && ((hs_cnt % int'(len)) == int'(len) - 1);
            if (hs_cnt == bad_beat) s_axis_tlast = ~s_axis_tlast;
            if (abort_at >= 0 && hs_cnt == abort_at) begin
                abort     = 1'b1;
                aborted   = 1'b1;
                hs_before = hs_cnt;
            end
            #4;
            hs = s_axis_tvalid && s_axis_tready;
            if (m_axis_tvalid != '0 || hs) begin
                if (hs_cnt < exp_ch.size()) begin
                    check({name, "_valid"}, m_axis_tvalid, 16'(1) << exp_ch[hs_cnt]);
                    check({name, "_ready"}, s_axis_tready, m_axis_tready[exp_ch[hs_cnt]]);
                    if (hs) check({name, "_data"}, m_axis_tdata, cur_data);
                end else begin
                    check({name, "_spurious_valid"}, m_axis_tvalid, 0);
                end
            end
            if (hs) begin
                hs_cnt++;
                cur_data = rand_data();
            end
            if (done) begin
                saw_done = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            if (aborted) break;
        end

        if (aborted) begin
            abort = 1'b0;
            for (int k = 0; k < blocks.size(); k++)
                if (hs_before >= (k + 1) * int'(len)) exp_loaded[blocks[k]] = 1'b1;
            for (int i = 0; i < 3; i++) begin
                s_axis_tvalid = 1'b1;
                #4;
                check({name, "_abort_busy"}, busy, 0);
                check({name, "_abort_done"}, done, 0);
                check({name, "_abort_tready"}, s_axis_tready, 0);
                check({name, "_abort_tvalid"}, m_axis_tvalid, 0);
                check({name, "_abort_loaded"}, loaded, exp_loaded);
                @(posedge clk); #1;
            end
            s_axis_tvalid = 1'b0;
        end else if (saw_done) begin
            if (exp_lat >= 0) check({name, "_done_latency"}, cyc, exp_lat);
            check({name, "_beats"}, hs_cnt, exp_ch.size());
            check({name, "_busy_at_done"}, busy, 1);
            @(posedge clk); #1;
            s_axis_tvalid = 1'b0;
            #4;
            check({name, "_done_pulse"}, done, 0);
            check({name, "_busy_after"}, busy, 0);
            if (!err_case) check({name, "_loaded"}, loaded, mask);
            check({name, "_err"}, err, err_case);
            @(posedge clk); #1;
        end else begin
            check({name, "_timeout"}, 0, 1);
        end
    endtask

    initial begin
        int tlast_lat;

        rst           = 1'b1;
        start         = 1'b0;
        abort         = 1'b0;
        ch_mask       = '0;
        load_len      = '0;
        s_axis_tdata  = rand_data();
        s_axis_tvalid = 1'b1;
        s_axis_tlast  = 1'b0;
        m_axis_tready = '1;
        repeat (3) @(posedge clk);
        #4;
        check("rst_tready", s_axis_tready, 0);
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_loaded", loaded, 0);
        check("rst_err", err, 0);
        check("rst_tdata_pass", m_axis_tdata, s_axis_tdata);
        @(posedge clk); #1;
        rst           = 1'b0;
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;

        run_pass("two_ch",  16'h0005, 16'd4, 0, 1'b0, -1, -1, -1, 12);
        run_pass("bp",      16'h0001, 16'd6, 1, 1'b0, -1, -1, -1, -1);
        run_pass("empty",   16'h0000, 16'd4, 0, 1'b0, -1, -1, -1, 2);
        run_pass("len0",    16'h0003, 16'd0, 0, 1'b0, -1, -1, -1, 4);
        run_pass("abort",   16'h0003, 16'd4, 0, 1'b0, -1, 6, -1, -1);
`ifdef DAC_LOAD_TLAST_CHECK_EN
        tlast_lat = 6;
`else
        tlast_lat = 12;
`endif
        run_pass("tlast",   16'h0003, 16'd4, 0, 1'b0, 2, -1, -1, tlast_lat);
        run_pass("restart", 16'h0012, 16'd3, 0, 1'b0, -1, -1, 2, 10);
        for (int i = 0; i < 6; i++)
            run_pass("rand", 16'($urandom), 16'($urandom_range(1, 5)), 2, 1'b1, -1, -1, -1, -1);

        // Reset partway into the second channel of a pass.
        ch_mask       = 16'h0003;
        load_len      = 16'd2;
        m_axis_tready = '1;
        for (int c = 0; c < 6; c++) begin
            start         = (c == 0);
            s_axis_tlast  = (c == 3);
            rst           = (c == 5);
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = rand_data();
            #4;
            if (c == 5) begin
                check("pre_rst_loaded", loaded, 16'h0001);
                check("pre_rst_busy", busy, 1);
            end
            @(posedge clk); #1;
        end
        rst   = 1'b0;
        start = 1'b0;
        #4;
        check("mid_rst_loaded", loaded, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_tready", s_axis_tready, 0);
        check("mid_rst_tvalid", m_axis_tvalid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
